// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one-shot digit strobe
//
// Purpose: drives the keypad rows one at a time (active-low), samples the
// synchronized column lines once per SCAN_DIV cycles, debounces presses and
// releases over DEBOUNCE consecutive samples and emits one digitValid strobe
// per confirmed key press.
//
// Ports:
//   CLK        in   1  system clock, rising edge
//   RST        in   1  asynchronous active-low reset
//   col        in   4  column lines, active-low, asynchronous to CLK
//   row        out  4  row drive, active-low one-hot
//   digit      out  4  key code of the last confirmed press
//   digitValid out  1  one-cycle strobe for a new digit
//   keyHeld    out  1  high while a confirmed key is still pressed
//   dbgState   out  2  current FSM state

module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] digit,
  output logic       digitValid,
  output logic       keyHeld,
  output logic [1:0] dbgState
);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_MAX   = 4'(DEBOUNCE);

  state_t      state, state_n;
  logic [3:0]  sync1, col_s;
  logic [15:0] div_cnt;
  logic [1:0]  row_idx, row_idx_n;
  logic [1:0]  lat_r, lat_r_n, lat_c, lat_c_n;
  logic [3:0]  db_cnt, db_cnt_n;
  logic [3:0]  digit_n;
  logic        digit_valid_n, key_held_n;
  logic        sample;
  logic        single_zero;
  logic [1:0]  zero_idx;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  assign sample   = (div_cnt == DIV_LAST);
  assign row      = ~(4'b0001 << row_idx);
  assign dbgState = state;

  // Exactly one closed column is the only pattern that identifies a key.
  always_comb begin
    single_zero = 1'b1;
    zero_idx    = 2'd0;
    case (col_s)
      4'b1110: zero_idx = 2'd0;
      4'b1101: zero_idx = 2'd1;
      4'b1011: zero_idx = 2'd2;
      4'b0111: zero_idx = 2'd3;
      default: single_zero = 1'b0;
    endcase
  end

  always_comb begin
    state_n       = state;
    row_idx_n     = row_idx;
    lat_r_n       = lat_r;
    lat_c_n       = lat_c;
    db_cnt_n      = db_cnt;
    digit_n       = digit;
    digit_valid_n = 1'b0;
    key_held_n    = keyHeld;
    if (sample) begin
      case (state)
        S_SCAN: begin
          if (single_zero) begin
            lat_r_n  = row_idx;
            lat_c_n  = zero_idx;
            db_cnt_n = 4'd1;
            state_n  = S_DEBOUNCE;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          // A count already at DEBOUNCE only happens for DEBOUNCE=1, where the
          // detection sample alone confirms the press.
          if (db_cnt >= DB_MAX ||
              (single_zero && zero_idx == lat_c && db_cnt + 4'd1 >= DB_MAX)) begin
            digit_n       = key_map(lat_r, lat_c);
            digit_valid_n = 1'b1;
            key_held_n    = 1'b1;
            db_cnt_n      = DB_MAX;
            state_n       = S_PRESSED;
          end else if (single_zero && zero_idx == lat_c) begin
            db_cnt_n = db_cnt + 4'd1;
          end else begin
            state_n   = S_SCAN;
            row_idx_n = row_idx + 2'd1;
          end
        end
        S_PRESSED: begin
          key_held_n = 1'b1;
          if (col_s == 4'b1111) begin
            db_cnt_n = 4'd1;
            state_n  = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (col_s == 4'b1111) begin
            if (db_cnt >= DB_MAX || db_cnt + 4'd1 >= DB_MAX) begin
              db_cnt_n   = DB_MAX;
              key_held_n = 1'b0;
              state_n    = S_SCAN;
              row_idx_n  = row_idx + 2'd1;
            end else begin
              db_cnt_n = db_cnt + 4'd1;
            end
          end else begin
            // Release bounce: fall back without a new strobe.
            state_n = S_PRESSED;
          end
        end
        default: state_n = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1      <= 4'b1111;
      col_s      <= 4'b1111;
      div_cnt    <= 16'd0;
      state      <= S_SCAN;
      row_idx    <= 2'd0;
      lat_r      <= 2'd0;
      lat_c      <= 2'd0;
      db_cnt     <= 4'd0;
      digit      <= 4'h0;
      digitValid <= 1'b0;
      keyHeld    <= 1'b0;
    end else begin
      sync1      <= col;
      col_s      <= sync1;
      div_cnt    <= sample ? 16'd0 : div_cnt + 16'd1;
      state      <= state_n;
      row_idx    <= row_idx_n;
      lat_r      <= lat_r_n;
      lat_c      <= lat_c_n;
      db_cnt     <= db_cnt_n;
      digit      <= digit_n;
      digitValid <= digit_valid_n;
      keyHeld    <= key_held_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with an emulated key matrix

module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] digit;
  logic       digitValid;
  logic       keyHeld;
  logic [1:0] dbgState;

  int checks = 0;
  int errors = 0;

  logic       pressed [4][4];
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] exp_q [$];
  logic [3:0] popped;
  bit         prev_valid = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .CLK(CLK), .RST(RST), .col(col), .row(row), .digit(digit),
    .digitValid(digitValid), .keyHeld(keyHeld), .dbgState(dbgState)
  );

  always #5 CLK = ~CLK;

  // Passive key matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !row[r]) col[c] = 1'b0;
  end

  // Monitor: every strobe must match the oldest outstanding expected digit.
  always @(negedge CLK) begin
    if (RST && digitValid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL digit_unexpected got %h expected no strobe", digit);
      end else begin
        popped = exp_q.pop_front();
        if (digit !== popped) begin
          errors++;
          $display("FAIL digit_value got %h expected %h", digit, popped);
        end
      end
      if (prev_valid) begin
        errors++;
        $display("FAIL strobe_back_to_back got 1 expected 0");
      end
    end
    prev_valid = digitValid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d pending digits expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic long_press(input int r, input int c, input bit make_bounce, input bit rel_bounce);
    logic [3:0] frozen;
    frozen = ~(4'b0001 << r);
    exp_q.push_back(kmap[r*4 + c]);
    if (make_bounce) begin
      pressed[r][c] = 1'b1; wait_cycles($urandom_range(1, 8));
      pressed[r][c] = 1'b0; wait_cycles($urandom_range(1, 8));
    end
    pressed[r][c] = 1'b1;
    wait_cycles(36);
    check("held_keyheld", {3'b0, keyHeld}, 4'd1);
    check("held_state", {2'b0, dbgState}, 4'd2);
    check("held_row_frozen", row, frozen);
    check_drained("press_digit_missing");
    wait_cycles($urandom_range(0, 20));
    if (rel_bounce) begin
      pressed[r][c] = 1'b0; wait_cycles($urandom_range(1, 8));
      pressed[r][c] = 1'b1; wait_cycles($urandom_range(1, 8));
      pressed[r][c] = 1'b0; wait_cycles($urandom_range(1, 8));
      pressed[r][c] = 1'b1; wait_cycles($urandom_range(1, 8));
      check("bounce_keyheld", {3'b0, keyHeld}, 4'd1);
    end
    pressed[r][c] = 1'b0;
    wait_cycles(5);
    check("release_early_keyheld", {3'b0, keyHeld}, 4'd1);
    wait_cycles(25);
    check("released_keyheld", {3'b0, keyHeld}, 4'd0);
    check("released_state", {2'b0, dbgState}, 4'd0);
  endtask

  initial begin
    logic [3:0] exp_row;
    logic [3:0] row_a;
    int r, c, c2, kind;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) pressed[i][j] = 1'b0;

    wait_cycles(3);
    check("reset_row", row, 4'b1110);
    check("reset_digit", digit, 4'h0);
    check("reset_valid", {3'b0, digitValid}, 4'd0);
    check("reset_keyheld", {3'b0, keyHeld}, 4'd0);
    check("reset_state", {2'b0, dbgState}, 4'd0);

    // Idle scan: each row held four cycles, rotating 0->1->2->3->0.
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge CLK);
      exp_row = ~(4'b0001 << (((k + 1) / 4) % 4));
      check("idle_row", row, exp_row);
    end

    // Directed: row2/col1 -> '8'; then '9' with release bounces.
    long_press(2, 1, 1'b0, 1'b0);
    long_press(2, 2, 1'b0, 1'b1);

    for (int it = 0; it < 14; it++) begin
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        long_press(r, c, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end else if (kind == 2) begin
        // Glitch too short to give three consecutive closed samples.
        pressed[r][c] = 1'b1;
        wait_cycles($urandom_range(1, 8));
        pressed[r][c] = 1'b0;
        wait_cycles(20);
        check("glitch_keyheld", {3'b0, keyHeld}, 4'd0);
      end else begin
        // Two columns in one row never identify a key; scanning continues.
        c2 = (c + $urandom_range(1, 3)) % 4;
        pressed[r][c]  = 1'b1;
        pressed[r][c2] = 1'b1;
        wait_cycles(40);
        row_a = row;
        wait_cycles(4);
        check("twokey_rotate", row, {row_a[2:0], row_a[3]});
        check("twokey_keyheld", {3'b0, keyHeld}, 4'd0);
        pressed[r][c]  = 1'b0;
        pressed[r][c2] = 1'b0;
        wait_cycles(20);
      end
    end

    // Reset while a key is held: press abandoned, same key detected again.
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    exp_q.push_back(kmap[r*4 + c]);
    pressed[r][c] = 1'b1;
    wait_cycles(36);
    check_drained("pre_reset_digit_missing");
    #2 RST = 1'b0;
    #1;
    check("midreset_row", row, 4'b1110);
    check("midreset_digit", digit, 4'h0);
    check("midreset_valid", {3'b0, digitValid}, 4'd0);
    check("midreset_keyheld", {3'b0, keyHeld}, 4'd0);
    check("midreset_state", {2'b0, dbgState}, 4'd0);
    wait_cycles(3);
    exp_q.push_back(kmap[r*4 + c]);
    RST = 1'b1;
    wait_cycles(40);
    check_drained("post_reset_digit_missing");
    check("post_reset_keyheld", {3'b0, keyHeld}, 4'd1);
    pressed[r][c] = 1'b0;
    wait_cycles(30);
    check("post_reset_released", {3'b0, keyHeld}, 4'd0);

    check_drained("final_pending");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
